// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and sizes for the 8-channel TDM demultiplexer.
// Optional TDM_DEMUX_PARITY_EN adds a 9th (parity) slot per frame.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_W    = 4;
    localparam int FRAME_LEN = NUM_SLOTS + 1;
`else
    localparam int SLOT_W    = 3;
    localparam int FRAME_LEN = NUM_SLOTS;
`endif

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

endpackage

// File: rtl/tdm_demux8_slot_dec.sv
// slot_dec: 3-to-8 one-hot write-enable decoder for the shadow register.
// Ports: en (write strobe), sel (slot index), we (one-hot enables).
module slot_dec (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] we
);

    always_comb begin
        we = 8'h00;
        if (en) begin
            we[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: serial TDM to 8-bit parallel frame demultiplexer.
// Ports: clk, rst_n (async low), din/din_valid/frame_sync in;
//   ch_out, frame_valid, locked, sync_err out; parity_err only
//   when TDM_DEMUX_PARITY_EN is defined (adds an even-parity slot 8).
module tdm_demux8
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       frame_sync,
    output logic [7:0] ch_out,
    output logic       frame_valid,
    output logic       locked,
    output logic       sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    state_t            state, state_n;
    logic [SLOT_W-1:0] slot, slot_n;
    logic [7:0]        shadow, shadow_n;
    logic [7:0]        ch_n;
    logic              fv_n;
    logic              se_n;
    logic              dec_en;
    logic [2:0]        dec_sel;
    logic [7:0]        we;
`ifdef TDM_DEMUX_PARITY_EN
    logic              pe_n;
`endif

    slot_dec u_dec (
        .en  (dec_en),
        .sel (dec_sel),
        .we  (we)
    );

    // The state flop is itself the registered lock indicator.
    assign locked = (state == RECV);

    always_comb begin
        state_n = state;
        slot_n  = slot;
        ch_n    = ch_out;
        fv_n    = 1'b0;
        se_n    = 1'b0;
        dec_en  = 1'b0;
        dec_sel = slot[2:0];
`ifdef TDM_DEMUX_PARITY_EN
        pe_n    = 1'b0;
`endif
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        dec_en  = 1'b1;
                        dec_sel = 3'd0;
                        slot_n  = SLOT_W'(1);
                        state_n = RECV;
                    end
                end
                RECV: begin
                    if (frame_sync && slot != '0) begin
                        // Early sync: restart the frame at this beat.
                        se_n    = 1'b1;
                        dec_en  = 1'b1;
                        dec_sel = 3'd0;
                        slot_n  = SLOT_W'(1);
                    end else if (!frame_sync && slot == '0) begin
                        se_n    = 1'b1;
                        state_n = HUNT;
                    end else begin
`ifdef TDM_DEMUX_PARITY_EN
                        // Slot 8 carries parity, not channel data.
                        dec_en = (slot != LAST_SLOT);
`else
                        dec_en = 1'b1;
`endif
                        if (slot == LAST_SLOT) begin
                            slot_n = '0;
                            fv_n   = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                            ch_n   = shadow;
                            pe_n   = din ^ (^shadow);
`else
                            ch_n   = {din, shadow[6:0]};
`endif
                        end else begin
                            slot_n = slot + 1'b1;
                        end
                    end
                end
            endcase
        end
        shadow_n = (shadow & ~we) | ({8{din}} & we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            shadow      <= 8'h00;
            ch_out      <= 8'h00;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            shadow      <= shadow_n;
            ch_out      <= ch_n;
            frame_valid <= fv_n;
            sync_err    <= se_n;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= pe_n;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed plus random checks of tdm_demux8 against
// a queue-based frame model; honours TDM_DEMUX_PARITY_EN.
module tb_tdm_demux8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] ch_out;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic       parity_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tdm_demux8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch_out      (ch_out),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    // Reference model: a frame is the list of bits received since sync.
    bit         m_locked;
    bit         q[$];
    logic [7:0] m_ch;
    bit         e_fv, e_se, e_pe;

    function void model_reset();
        m_locked = 0;
        q.delete();
        m_ch = 8'h00;
        e_fv = 0;
        e_se = 0;
        e_pe = 0;
    endfunction

    function void model_beat(bit d, bit fs);
        e_fv = 0;
        e_se = 0;
        e_pe = 0;
        if (!m_locked) begin
            if (fs) begin
                q.delete();
                q.push_back(d);
                m_locked = 1;
            end
        end else if (fs && q.size() != 0) begin
            e_se = 1;
            q.delete();
            q.push_back(d);
        end else if (!fs && q.size() == 0) begin
            e_se = 1;
            m_locked = 0;
        end else begin
            q.push_back(d);
            if (q.size() == FL) begin
                for (int i = 0; i < 8; i++) m_ch[i] = q[i];
                if (FL == 9) e_pe = (q[FL-1] != (^m_ch));
                e_fv = 1;
                q.delete();
            end
        end
    endfunction

    task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("ch_out", ch_out, m_ch);
        check("frame_valid", {7'd0, frame_valid}, {7'd0, e_fv});
        check("locked", {7'd0, locked}, {7'd0, m_locked});
        check("sync_err", {7'd0, sync_err}, {7'd0, e_se});
`ifdef TDM_DEMUX_PARITY_EN
        check("parity_err", {7'd0, parity_err}, {7'd0, e_pe});
`endif
    endtask

    task automatic step(bit v, bit d, bit fs);
        din_valid = v;
        din = d;
        frame_sync = fs;
        @(posedge clk);
        #1;
        if (v) model_beat(d, fs);
        else begin
            e_fv = 0;
            e_se = 0;
            e_pe = 0;
        end
        check_all();
        din_valid = 1'b0;
    endtask

    task automatic beat(bit d, bit fs, int gap);
        step(1'b1, d, fs);
        for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic send_frame(logic [7:0] b, int gap, bit flip);
        for (int i = 0; i < 8; i++) beat(b[i], i == 0, gap);
`ifdef TDM_DEMUX_PARITY_EN
        beat((^b) ^ flip, 1'b0, gap);
`else
        if (flip) begin end
`endif
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    logic [7:0] b;
    int n_fv;
    int n_se;

    initial begin
        din_valid = 1'b0;
        model_reset();

        hard_reset();
        check("reset_ch", ch_out, 8'h00);

        // Basic frame 8'h65, locked visible from beat 2.
        beat(1'b1, 1'b1, 0);
        check("lock_beat2", {7'd0, locked}, 8'd1);
        b = 8'h65;
        for (int i = 1; i < 8; i++) beat(b[i], 1'b0, 0);
`ifdef TDM_DEMUX_PARITY_EN
        beat(1'b0, 1'b0, 0);
`endif
        check("basic_fv", {7'd0, frame_valid}, 8'd1);
        check("basic_ch", ch_out, 8'h65);
        step(1'b0, 1'b0, 1'b0);
        check("basic_fv_once", {7'd0, frame_valid}, 8'd0);

        // Gapped back-to-back frames.
        n_se = 0;
        send_frame(8'hA5, 3, 1'b0);
        check("gap_a5", ch_out, 8'hA5);
        send_frame(8'h3C, 3, 1'b0);
        check("gap_3c", ch_out, 8'h3C);

        // Early sync on slot 4, then the restarted frame completes.
        b = 8'h0F;
        for (int i = 0; i < 4; i++) beat(b[i], i == 0, 1);
        beat(1'b1, 1'b1, 0);
        check("early_se", {7'd0, sync_err}, 8'd1);
        check("early_nofv", {7'd0, frame_valid}, 8'd0);
        b = 8'hB3;
        for (int i = 1; i < 8; i++) beat(b[i], 1'b0, 0);
`ifdef TDM_DEMUX_PARITY_EN
        beat(^b, 1'b0, 0);
`endif
        check("early_ch", ch_out, 8'hB3);

        // Missing sync at slot 0.
        beat(1'b1, 1'b0, 0);
        check("miss_se", {7'd0, sync_err}, 8'd1);
        check("miss_unlock", {7'd0, locked}, 8'd0);
        check("miss_hold", ch_out, 8'hB3);

        // Reset mid-frame after slot 3.
        b = 8'hFF;
        for (int i = 0; i < 4; i++) beat(b[i], i == 0, 0);
        hard_reset();
        check("mid_rst_ch", ch_out, 8'h00);
        send_frame(8'h5A, 0, 1'b0);
        check("post_rst_ch", ch_out, 8'h5A);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(8'h65, 0, 1'b1);
        check("par_err", {7'd0, parity_err}, 8'd1);
        check("par_ch", ch_out, 8'h65);
`endif

        // Random traffic: clean frames mixed with junk beats.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int j = 0; j < 6; j++) begin
                    step($urandom_range(0, 3) != 0, 1'($urandom),
                         $urandom_range(0, 5) == 0);
                end
            end else begin
                send_frame(8'($urandom), $urandom_range(0, 2),
                           $urandom_range(0, 3) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk (rising edge), rst_n (asserting low resets immediately; release is synchronous to clk).
REQ-002 Port clk, input, 1 bit: sole clock.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port din, input, 1 bit: serial TDM data, one channel bit per valid beat.
REQ-005 Port din_valid, input, 1 bit: din and frame_sync are sampled only when this is high.
REQ-006 Port frame_sync, input, 1 bit: marks the beat carrying slot 0.
REQ-007 Port ch_out, output, 8 bits: last complete frame; bit k is slot k.
REQ-008 Port frame_valid, output, 1 bit: one-cycle pulse when ch_out updates.
REQ-009 Port locked, output, 1 bit: high while in state RECV.
REQ-010 Port sync_err, output, 1 bit: one-cycle pulse on a framing violation.
REQ-011 Port parity_err, output, 1 bit: exists only with TDM_DEMUX_PARITY_EN.

Function
REQ-012 The FSM SHALL have states HUNT and RECV, plus a 3-bit slot counter and an 8-bit shadow register.
REQ-013 In HUNT, a beat with din_valid=1 and frame_sync=1 SHALL write din to shadow[0], set slot to 1, and move to RECV. Beats without frame_sync SHALL be discarded.
REQ-014 In RECV, each din_valid=1 beat SHALL write din to shadow[slot] and increment slot. The slot counter wraps from 7 to 0.
REQ-015 On the slot-7 beat, the block SHALL, on the next clock edge, load ch_out with shadow[6:0] plus the slot-7 bit, and pulse frame_valid for exactly one cycle. Latency is 1 cycle from the last beat.
REQ-016 din_valid=0 SHALL hold all state. Gaps of any length between beats are legal.
REQ-017 In RECV, a beat with frame_sync=1 while slot!=0 SHALL:
- pulse sync_err;
- discard the partial frame;
- store din in shadow[0] and set slot to 1;
- stay in RECV.
REQ-018 In RECV, a beat with slot=0 and frame_sync=0 SHALL pulse sync_err, discard the bit, and return to HUNT.
REQ-019 ch_out SHALL change only when frame_valid pulses. An incomplete frame never reaches ch_out.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 While rst_n=0, the block SHALL hold:
- state=HUNT, slot=0, shadow=0;
- ch_out=8'h00;
- frame_valid=0, locked=0, sync_err=0, parity_err=0.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no frame_valid pulse. After release, the block SHALL restart in HUNT.

Configuration
REQ-023 Macro TDM_DEMUX_PARITY_EN SHALL control a parity slot.
REQ-024 With the macro defined:
- each frame carries a 9th beat (slot 8, 4-bit counter), the even-parity bit of slots 0-7;
- ch_out and frame_valid update 1 cycle after the parity beat;
- parity_err pulses with frame_valid on mismatch, and ch_out still updates;
- frame_sync on slot 8 follows the REQ-017 rule.
REQ-025 With the macro undefined, frames SHALL be 8 beats, and no parity_err port or parity logic SHALL exist.

Structure
REQ-026 Package tdm_pkg SHALL hold:
- state encoding (HUNT=1'b0, RECV=1'b1);
- NUM_SLOTS=8;
- SLOT_W, which is 3, or 4 with parity.
REQ-027 Sub-module slot_dec SHALL be a 3-to-8 one-hot write-enable decoder driven by slot, gated by din_valid and RECV or the HUNT capture condition.

Verification
REQ-028 Basic frame: reset, then 8 contiguous beats sending 1,0,1,0,0,1,1,0 for slots 0-7, frame_sync on the first beat -> ch_out=8'h65 and frame_valid pulse 1 cycle after beat 8; locked=1 from beat 2.
REQ-029 Gapped back-to-back frames: send 8'hA5 then 8'h3C, with din_valid low for 3 cycles between beats -> two frame_valid pulses, ch_out=8'hA5 then 8'h3C, sync_err never high.
REQ-030 Early sync: frame_sync on the slot-4 beat -> sync_err pulse, no frame_valid, and the next 7 beats complete a frame starting from that beat.
REQ-031 Missing sync: slot-0 beat without frame_sync -> sync_err pulse, locked falls, and ch_out holds its previous value.
REQ-032 Reset mid-frame: assert rst_n=0 after slot 3 -> all outputs zero immediately; the next full frame decodes correctly.
REQ-033 With TDM_DEMUX_PARITY_EN: frame 8'h65 with parity 0 -> parity_err=0; the same frame with parity 1 -> parity_err pulses with frame_valid and ch_out=8'h65.
